// File: rtl/audio_mixer_pkg.sv
// Shared definitions for the audio mixer: FSM state encoding, sample/volume
// widths, the volume ceiling and the volume clamp helper.
package audio_mixer_pkg;

   localparam int SAMPLE_W = 8;
   localparam int VOL_W    = 7;
   localparam int PROD_W   = SAMPLE_W + VOL_W;
   localparam int OUT_W    = PROD_W + 1;
   localparam logic [VOL_W-1:0] VOL_CEIL = 7'd64;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      MUL3 = 3'd4,
      OUT  = 3'd5
   } mixState_t;

   function automatic logic [VOL_W-1:0] clampVol(input logic [VOL_W-1:0] vol);
      logic [VOL_W-1:0] res;
      if (vol > VOL_CEIL) begin
         res = VOL_CEIL;
      end else begin
         res = vol;
      end
      return res;
   endfunction

endpackage

// File: rtl/audio_mixer_tick_gen.sv
// Sample-rate tick generator: counts 0..DIV-1 and flags the cycle whose
// closing edge wraps the counter back to zero.
module audio_tick_gen #(
   parameter int REF_CLK     = 24000000,
   parameter int SAMPLE_RATE = 48000
) (
   input  logic iCLK,
   input  logic iRST,
   output logic oTICK
);

   localparam int DIV   = REF_CLK / SAMPLE_RATE;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (DIV < 8) begin : gDivCheck
         $error("audio_tick_gen: REF_CLK/SAMPLE_RATE must be at least 8");
      end
   endgenerate

   logic [CNT_W-1:0] tickCnt_r;
   logic             tick_r;

   // Divider counter; tick_r is set one cycle ahead so it is high while the counter sits at DIV-1
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         tickCnt_r <= '0;
         tick_r    <= 1'b0;
      end else begin
         if (tickCnt_r == CNT_LAST) begin
            tickCnt_r <= '0;
         end else begin
            tickCnt_r <= tickCnt_r + CNT_ONE;
         end
         tick_r <= (tickCnt_r == CNT_PRE);
      end
   end

   assign oTICK = tick_r;

endmodule

// File: rtl/audio_mixer.sv
// Four-channel volume mixer: snapshots inputs on each sample tick, runs them
// through one shared multiplier over four cycles and publishes a stereo pair.
module audio_mixer
   import audio_mixer_pkg::*;
#(
   parameter int REF_CLK     = 24000000,
   parameter int SAMPLE_RATE = 48000
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iMUTE,
   input  logic [SAMPLE_W-1:0] iCH0,
   input  logic [SAMPLE_W-1:0] iCH1,
   input  logic [SAMPLE_W-1:0] iCH2,
   input  logic [SAMPLE_W-1:0] iCH3,
   input  logic [VOL_W-1:0]    iVOL0,
   input  logic [VOL_W-1:0]    iVOL1,
   input  logic [VOL_W-1:0]    iVOL2,
   input  logic [VOL_W-1:0]    iVOL3,
   output logic [OUT_W-1:0]    oSL,
   output logic [OUT_W-1:0]    oSR,
   output logic                oVALID
);

   logic                           tick_s;
   mixState_t                      state_r;
   mixState_t                      nextState_s;
   logic [3:0][SAMPLE_W-1:0]       chSnap_r;
   logic [3:0][VOL_W-1:0]          volSnap_r;
   logic signed [PROD_W-1:0]       leftSum_r;
   logic signed [PROD_W-1:0]       rightSum_r;
   logic [1:0]                     mulSel_s;
   logic                           mulActive_s;
   logic                           mulLeft_s;
   logic signed [PROD_W-1:0]       chExt_s;
   logic signed [PROD_W-1:0]       volExt_s;
   logic signed [PROD_W-1:0]       prod_s;

   audio_tick_gen #(
      .REF_CLK     (REF_CLK),
      .SAMPLE_RATE (SAMPLE_RATE)
   ) uTickGen (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .oTICK (tick_s)
   );

   // FSM state register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state logic and multiplier operand select
   always_comb begin
      nextState_s = state_r;
      mulSel_s    = 2'd0;
      mulActive_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (tick_s) begin
               nextState_s = MUL0;
            end else begin
               nextState_s = IDLE;
            end
         end
         MUL0: begin
            mulSel_s    = 2'd0;
            mulActive_s = 1'b1;
            nextState_s = MUL1;
         end
         MUL1: begin
            mulSel_s    = 2'd1;
            mulActive_s = 1'b1;
            nextState_s = MUL2;
         end
         MUL2: begin
            mulSel_s    = 2'd2;
            mulActive_s = 1'b1;
            nextState_s = MUL3;
         end
         MUL3: begin
            mulSel_s    = 2'd3;
            mulActive_s = 1'b1;
            nextState_s = OUT;
         end
         OUT: begin
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // Channels 0 and 3 feed the left bus, 1 and 2 the right bus
   assign mulLeft_s = (mulSel_s == 2'd0) || (mulSel_s == 2'd3);

   // Sign-extended sample times zero-extended volume; the product always fits PROD_W bits
   assign chExt_s  = PROD_W'($signed(chSnap_r[mulSel_s]));
   assign volExt_s = {{(PROD_W - VOL_W){1'b0}}, volSnap_r[mulSel_s]};
   assign prod_s   = chExt_s * volExt_s;

   // Input snapshot on the tick edge and per-side accumulation during MUL0..MUL3
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         chSnap_r   <= '0;
         volSnap_r  <= '0;
         leftSum_r  <= '0;
         rightSum_r <= '0;
      end else if ((state_r == IDLE) && tick_s) begin
         chSnap_r   <= {iCH3, iCH2, iCH1, iCH0};
         volSnap_r  <= {clampVol(iVOL3), clampVol(iVOL2), clampVol(iVOL1), clampVol(iVOL0)};
         leftSum_r  <= '0;
         rightSum_r <= '0;
      end else if (mulActive_s) begin
         if (mulLeft_s) begin
            leftSum_r <= leftSum_r + prod_s;
         end else begin
            rightSum_r <= rightSum_r + prod_s;
         end
      end
   end

   // Publish the stereo pair and strobe oVALID for one cycle in OUT
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oSL    <= '0;
         oSR    <= '0;
         oVALID <= 1'b0;
      end else if (state_r == OUT) begin
         oVALID <= 1'b1;
         if (iMUTE) begin
            oSL <= '0;
            oSR <= '0;
         end else begin
            oSL <= {leftSum_r, 1'b0};
            oSR <= {rightSum_r, 1'b0};
         end
      end else begin
         oVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: directed corner cases plus randomized
// samples compared against an arithmetic mixing model.
module tb_audio_mixer;

   localparam int DIV = 500;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iMUTE;
   logic [7:0]  iCH0, iCH1, iCH2, iCH3;
   logic [6:0]  iVOL0, iVOL1, iVOL2, iVOL3;
   logic [15:0] oSL, oSR;
   logic        oVALID;

   logic [7:0]  curCh   [4];
   logic [6:0]  curVol  [4];
   logic [7:0]  postCh  [4];
   logic [6:0]  postVol [4];
   bit          usePost;

   int checks   = 0;
   int errors   = 0;
   int edges    = 0;
   int spurious = 0;

   assign iCH0  = curCh[0];
   assign iCH1  = curCh[1];
   assign iCH2  = curCh[2];
   assign iCH3  = curCh[3];
   assign iVOL0 = curVol[0];
   assign iVOL1 = curVol[1];
   assign iVOL2 = curVol[2];
   assign iVOL3 = curVol[3];

   audio_mixer #(
      .REF_CLK     (24000000),
      .SAMPLE_RATE (48000)
   ) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iMUTE  (iMUTE),
      .iCH0   (iCH0),
      .iCH1   (iCH1),
      .iCH2   (iCH2),
      .iCH3   (iCH3),
      .iVOL0  (iVOL0),
      .iVOL1  (iVOL1),
      .iVOL2  (iVOL2),
      .iVOL3  (iVOL3),
      .oSL    (oSL),
      .oSR    (oSR),
      .oVALID (oVALID)
   );

   always #5 iCLK = ~iCLK;

   task automatic checkVal(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Published value of one side: twice the sum of two clamped channel products
   function automatic int sideMix(input logic [7:0] ca, input logic [6:0] va,
                                  input logic [7:0] cb, input logic [6:0] vb);
      int a, b, wa, wb;
      a  = $signed(ca);
      b  = $signed(cb);
      wa = (va > 7'd64) ? 64 : int'(va);
      wb = (vb > 7'd64) ? 64 : int'(vb);
      return 2 * (a * wa + b * wb);
   endfunction

   task automatic stepEdge();
      @(posedge iCLK);
      edges++;
      #1;
   endtask

   task automatic goToEdge(input int target);
      while (edges < target) begin
         stepEdge();
         if (oVALID === 1'b1) spurious++;
      end
   endtask

   task automatic runSample(input string tag);
      int t, arrival, expL, expR;
      t = (edges / DIV + 1) * DIV;
      goToEdge(t);
      checkVal({tag, "_stray"}, spurious, 0);
      spurious = 0;
      expL = sideMix(curCh[0], curVol[0], curCh[3], curVol[3]);
      expR = sideMix(curCh[1], curVol[1], curCh[2], curVol[2]);
      stepEdge();
      arrival = (oVALID === 1'b1) ? edges : -1;
      if (usePost) begin
         for (int i = 0; i < 4; i++) begin
            curCh[i]  = postCh[i];
            curVol[i] = postVol[i];
         end
         usePost = 1'b0;
      end
      while (arrival < 0 && edges < t + 20) begin
         stepEdge();
         if (oVALID === 1'b1) arrival = edges;
      end
      checkVal({tag, "_latency"}, arrival, t + 5);
      if (iMUTE) begin
         expL = 0;
         expR = 0;
      end
      checkVal({tag, "_left"}, $signed(oSL), expL);
      checkVal({tag, "_right"}, $signed(oSR), expR);
      stepEdge();
      checkVal({tag, "_pulse"}, oVALID, 1'b0);
      checkVal({tag, "_hold"}, $signed(oSL), expL);
   endtask

   task automatic clearInputs();
      for (int i = 0; i < 4; i++) begin
         curCh[i]  = 8'd0;
         curVol[i] = 7'd0;
      end
   endtask

   initial begin
      int t;
      iRST    = 1'b1;
      iMUTE   = 1'b0;
      usePost = 1'b0;
      clearInputs();
      repeat (3) @(posedge iCLK);
      #1;
      checkVal("reset_left", $signed(oSL), 0);
      checkVal("reset_right", $signed(oSR), 0);
      checkVal("reset_valid", oVALID, 1'b0);
      @(negedge iCLK);
      iRST  = 1'b0;
      edges = 0;

      runSample("zero");

      curCh[0] = 8'd127; curVol[0] = 7'd64;
      runSample("ch0_max");

      curCh[0] = 8'h80; curVol[0] = 7'd64;
      curCh[3] = 8'h80; curVol[3] = 7'd64;
      curCh[1] = 8'd127; curVol[1] = 7'd100;
      curCh[2] = 8'd127; curVol[2] = 7'd100;
      runSample("extremes");

      clearInputs();
      curCh[0] = 8'd10; curVol[0] = 7'd64;
      for (int i = 0; i < 4; i++) begin
         postCh[i]  = curCh[i];
         postVol[i] = curVol[i];
      end
      postCh[0] = 8'd100;
      usePost   = 1'b1;
      runSample("snap_old");
      runSample("snap_new");

      curCh[1] = 8'hC0; curVol[1] = 7'd33;
      iMUTE = 1'b1;
      runSample("muted");
      iMUTE = 1'b0;
      runSample("unmuted");

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 4; i++) begin
            curCh[i]   = 8'($urandom_range(255, 0));
            curVol[i]  = 7'($urandom_range(127, 0));
            postCh[i]  = 8'($urandom_range(255, 0));
            postVol[i] = 7'($urandom_range(127, 0));
         end
         usePost = 1'b1;
         iMUTE   = ($urandom_range(3, 0) == 0);
         runSample("random");
      end

      clearInputs();
      iMUTE = 1'b0;
      curCh[0] = 8'd100; curVol[0] = 7'd64;
      curCh[1] = 8'd50;  curVol[1] = 7'd64;
      runSample("pre_abort");
      t = (edges / DIV + 1) * DIV;
      goToEdge(t);
      stepEdge();
      stepEdge();
      #1 iRST = 1'b1;
      #1;
      checkVal("abort_left", $signed(oSL), 0);
      checkVal("abort_right", $signed(oSR), 0);
      checkVal("abort_valid", oVALID, 1'b0);
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST     = 1'b0;
      edges    = 0;
      spurious = 0;
      runSample("after_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter REF_CLK, default 24000000, input clock frequency in Hz.
REQ-002 Parameter SAMPLE_RATE, default 48000, output sample rate in Hz; DIV = REF_CLK/SAMPLE_RATE (500 at defaults).
REQ-003 iCLK  input  1  system clock, 24 MHz; all logic on posedge.
REQ-004 iRST  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 iMUTE  input  1  1 = published samples forced to zero.
REQ-006 iCH0..iCH3  input  8 each  channel samples, two's complement.
REQ-007 iVOL0..iVOL3  input  7 each  channel volume, unsigned, 0..64 meaningful.
REQ-008 oSL  output  16  left sample, two's complement, held between publishes.
REQ-009 oSR  output  16  right sample, two's complement, held between publishes.
REQ-010 oVALID  output  1  one-cycle pulse when oSL/oSR take new values.

Function
REQ-011 Tick counter SHALL count 0..DIV-1 and wrap; the tick edge is the edge on which the counter goes DIV-1 -> 0.
REQ-012 On the tick edge, all iCHn and iVOLn SHALL be snapshotted; input changes after that edge SHALL NOT affect the current sample.
REQ-013 Volume SHALL be clamped: snapshotted iVOLn > 64 SHALL be treated as 64.
REQ-014 FSM states: IDLE, MUL0, MUL1, MUL2, MUL3, OUT; IDLE -> MUL0 on tick edge; MULn -> next each edge; MUL3 -> OUT; OUT -> IDLE.
REQ-015 In MULn, one shared 8x7 signed-by-unsigned multiplier SHALL form Pn = CHn*VOLn (15-bit signed, range -8192..+8128).
REQ-016 P0 and P3 SHALL accumulate into the left sum; P1 and P2 SHALL accumulate into the right sum; each sum is 15-bit signed (range -16384..+16256); accumulators clear on the tick edge.
REQ-017 On the OUT edge: oSL = {left_sum, 1'b0} and oSR = {right_sum, 1'b0}, or both 0 if iMUTE (sampled on that edge) is 1; oVALID = 1 for exactly that one cycle.
REQ-018 No saturation logic SHALL exist; the ranges in REQ-016 guarantee no overflow.
REQ-019 Latency: outputs and oVALID change on the 5th edge after the tick edge; oVALID period is exactly DIV cycles.
REQ-020 DIV < 8 SHALL be rejected at elaboration; a tick therefore never occurs outside IDLE.

Reset
REQ-021 iRST high SHALL asynchronously force: counter 0, FSM IDLE, accumulators 0, snapshots 0, oSL 0, oSR 0, oVALID 0.
REQ-022 Reset asserted mid-sequence SHALL abort it; no oVALID pulse for that sample; counting restarts from 0 after release.

Structure
REQ-023 Shared header audio_defs.vh SHALL hold FSM state encodings, sample/volume widths, and the volume ceiling 64.
REQ-024 The tick counter SHALL be the sub-module audio_tick_gen (parameters REF_CLK, SAMPLE_RATE; ports iCLK, iRST, oTICK).
REQ-025 oSL/oSR SHALL connect directly to iSL/iSR of the downstream I2S serializer; the serializer samples them at its own LR rate with no handshake.

Verification
REQ-026 Release reset, all inputs 0 -> first oVALID high after edge 505, then every 500 cycles; oSL = oSR = 0.
REQ-027 iCH0=127, iVOL0=64, others 0 -> oSL = 16256 (0x3F80), oSR = 0.
REQ-028 iCH0=iCH3=-128, iVOL0=iVOL3=64 -> oSL = -32768 (0x8000); iCH1=iCH2=127, iVOL1=iVOL2=100 -> oSR = 32512 (0x7F00), clamp exercised.
REQ-029 Change iCH0 from 10 to 100 one cycle after the tick edge (iVOL0=64) -> that sample's oSL = 1280; the next sample's oSL = 12800.
REQ-030 iMUTE=1 with nonzero mix -> oVALID still pulses, oSL = oSR = 0; clear iMUTE -> the next sample has the correct nonzero value.
REQ-031 Assert iRST during MUL2 -> outputs 0 immediately, no oVALID for that sample; after release, the next oVALID follows edge 505.
